// File: rtl/uart_rcv_block.sv
// rtl/uart_rcv_block.sv - UART receive front end: start/data/stop framing and one-character buffer
// Define UART_RCV_SYNC_EN to add a 2-flop synchronizer ahead of the line register.
module uart_rcv_block (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        serial_in_i,
    input  logic [3:0]  data_size_i,
    input  logic [13:0] bit_period_i,
    input  logic        data_read_i,
    output logic [7:0]  rx_data_o,
    output logic        data_ready_o,
    output logic        overrun_error_o,
    output logic        framing_error_o
);
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, LOAD} state_t;

    state_t      state_q;
    logic        line_d, line_q, prev_q;
    logic        start_det;
    logic [13:0] cnt_q, p_q, p_d, half;
    logic [3:0]  bit_q, n_q, n_d;
    logic [7:0]  shift_q;
    logic        stop_q;

`ifdef UART_RCV_SYNC_EN
    logic [1:0] sync_q;
    always_ff @(posedge clk_i) begin
        if (rst_i) sync_q <= 2'b11;
        else       sync_q <= {sync_q[0], serial_in_i};
    end
    assign line_d = sync_q[1];
`else
    assign line_d = serial_in_i;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            line_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            line_q <= line_d;
            prev_q <= line_q;
        end
    end

    assign start_det = ~line_q & prev_q;
    assign n_d  = (data_size_i >= 4'd5 && data_size_i <= 4'd8) ? data_size_i : 4'd8;
    assign p_d  = (bit_period_i < 14'd4) ? 14'd4 : bit_period_i;
    assign half = {1'b0, p_q[13:1]};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q         <= IDLE;
            cnt_q           <= 14'd0;
            bit_q           <= 4'd0;
            shift_q         <= 8'h00;
            stop_q          <= 1'b0;
            n_q             <= 4'd8;
            p_q             <= 14'd4;
            rx_data_o       <= 8'h00;
            data_ready_o    <= 1'b0;
            overrun_error_o <= 1'b0;
            framing_error_o <= 1'b0;
        end else begin
            // LOAD owns the buffer flags in its cycle; a read there is folded in below
            if (data_read_i && state_q != LOAD) begin
                data_ready_o    <= 1'b0;
                overrun_error_o <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (start_det) begin
                        state_q <= START;
                        cnt_q   <= 14'd0;
                        n_q     <= n_d;
                        p_q     <= p_d;
                    end
                end
                START: begin
                    if (cnt_q == half - 14'd1) begin
                        cnt_q   <= 14'd0;
                        bit_q   <= 4'd0;
                        state_q <= line_q ? IDLE : DATA;
                    end else begin
                        cnt_q <= cnt_q + 14'd1;
                    end
                end
                DATA: begin
                    if (cnt_q == p_q - 14'd1) begin
                        cnt_q   <= 14'd0;
                        shift_q <= {line_q, shift_q[7:1]};
                        if (bit_q == n_q - 4'd1) state_q <= STOP;
                        else                     bit_q   <= bit_q + 4'd1;
                    end else begin
                        cnt_q <= cnt_q + 14'd1;
                    end
                end
                STOP: begin
                    if (cnt_q == p_q - 14'd1) begin
                        cnt_q   <= 14'd0;
                        stop_q  <= line_q;
                        state_q <= LOAD;
                    end else begin
                        cnt_q <= cnt_q + 14'd1;
                    end
                end
                LOAD: begin
                    if (stop_q) begin
                        rx_data_o       <= shift_q >> (4'd8 - n_q);
                        data_ready_o    <= 1'b1;
                        framing_error_o <= 1'b0;
                        if (data_read_i)       overrun_error_o <= 1'b0;
                        else if (data_ready_o) overrun_error_o <= 1'b1;
                    end else begin
                        framing_error_o <= 1'b1;
                    end
                    // A start edge landing in LOAD still begins the next frame
                    if (start_det) begin
                        state_q <= START;
                        cnt_q   <= 14'd0;
                        n_q     <= n_d;
                        p_q     <= p_d;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rcv_block.sv
// tb/tb_uart_rcv_block.sv - randomized self-checking bench for uart_rcv_block
module tb_uart_rcv_block;
`ifdef UART_RCV_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_i, serial_in_i, data_read_i;
    logic [3:0]  data_size_i;
    logic [13:0] bit_period_i;
    logic [7:0]  rx_data_o;
    logic        data_ready_o, overrun_error_o, framing_error_o;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] m_data;
    logic       m_ready, m_ovr, m_fe;

    always #5 clk = ~clk;

    uart_rcv_block dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .serial_in_i    (serial_in_i),
        .data_size_i    (data_size_i),
        .bit_period_i   (bit_period_i),
        .data_read_i    (data_read_i),
        .rx_data_o      (rx_data_o),
        .data_ready_o   (data_ready_o),
        .overrun_error_o(overrun_error_o),
        .framing_error_o(framing_error_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".rx_data"}, rx_data_o, m_data);
        check({tag, ".ready"}, data_ready_o, m_ready);
        check({tag, ".overrun"}, overrun_error_o, m_ovr);
        check({tag, ".framing"}, framing_error_o, m_fe);
    endtask

    task automatic pulse_read(input string tag);
        data_read_i = 1'b1;
        tick();
        data_read_i = 1'b0;
        m_ready = 1'b0;
        m_ovr   = 1'b0;
        check_outputs(tag);
    endtask

    // Drives one whole frame cycle by cycle, then updates the reference state.
    task automatic send_frame(input logic [7:0] data, input int ds, input int bp, input bit stop,
                              input int tail, input bit read_at_load, input int rst_c,
                              input bit chk_lat);
        int ne, pe, h, total, lat_c, rd_c, rise_c, b;
        bit was_ready;
        ne = (ds >= 5 && ds <= 8) ? ds : 8;
        pe = (bp < 4) ? 4 : bp;
        h  = pe / 2;
        data_size_i  = ds[3:0];
        bit_period_i = bp[13:0];
        total  = (ne + 2) * pe + tail;
        lat_c  = h + (ne + 1) * pe + 2 + SYNC_LAT;
        rd_c   = read_at_load ? lat_c : -1;
        rise_c = -1;
        was_ready = m_ready;
        for (int c = 0; c < total; c++) begin
            b = c / pe;
            if (b == 0)           serial_in_i = 1'b0;
            else if (b <= ne)     serial_in_i = data[b-1];
            else if (b == ne + 1) serial_in_i = stop;
            else                  serial_in_i = 1'b1;
            data_read_i = (c == rd_c);
            rst_i       = (c == rst_c);
            if (c == 2 * pe) begin
                data_size_i  = 4'($urandom_range(0, 15));
                bit_period_i = 14'($urandom_range(0, 40));
            end
            tick();
            if (rise_c < 0 && data_ready_o) rise_c = c;
        end
        data_read_i = 1'b0;
        rst_i       = 1'b0;
        serial_in_i = 1'b1;
        if (rst_c >= 0) begin
            m_data = 8'h00; m_ready = 1'b0; m_ovr = 1'b0; m_fe = 1'b0;
        end else if (stop) begin
            if (read_at_load) m_ovr = 1'b0;
            else if (m_ready) m_ovr = 1'b1;
            m_data  = data & (8'hFF >> (8 - ne));
            m_ready = 1'b1;
            m_fe    = 1'b0;
        end else begin
            m_fe = 1'b1;
        end
        if (chk_lat && stop && !was_ready && rst_c < 0)
            check("ready_latency", rise_c, lat_c);
    endtask

    initial begin
        logic [7:0] d;
        int ds, bp;
        bit st, rl;
        rst_i = 1'b1; serial_in_i = 1'b1; data_read_i = 1'b0;
        data_size_i = 4'd8; bit_period_i = 14'd10;
        m_data = 8'h00; m_ready = 1'b0; m_ovr = 1'b0; m_fe = 1'b0;
        repeat (3) tick();
        check_outputs("reset");
        rst_i = 1'b0;
        repeat (4) tick();

        send_frame(8'hA5, 8, 10, 1'b1, 8, 1'b0, -1, 1'b1);
        check_outputs("clean8");
        pulse_read("clean8_read");

        send_frame(8'h15, 5, 16, 1'b1, 8, 1'b0, -1, 1'b1);
        check_outputs("size5");
        pulse_read("size5_read");

        send_frame(8'h3C, 8, 10, 1'b0, 8, 1'b0, -1, 1'b0);
        check_outputs("framing_bad");
        send_frame(8'h3C, 8, 10, 1'b1, 8, 1'b0, -1, 1'b1);
        check_outputs("framing_good");
        pulse_read("framing_read");

        send_frame(8'h11, 8, 10, 1'b1, 8, 1'b0, -1, 1'b1);
        send_frame(8'h22, 8, 10, 1'b1, 8, 1'b0, -1, 1'b0);
        check_outputs("overrun");
        pulse_read("overrun_read");

        data_size_i = 4'd8; bit_period_i = 14'd10;
        serial_in_i = 1'b0;
        repeat (3) tick();
        serial_in_i = 1'b1;
        repeat (30) tick();
        check_outputs("glitch");

        send_frame(8'hFF, 8, 10, 1'b1, 8, 1'b0, 35, 1'b0);
        check_outputs("rst_mid");
        send_frame(8'h5A, 8, 10, 1'b1, 8, 1'b0, -1, 1'b1);
        check_outputs("after_rst");

        send_frame(8'h77, 8, 10, 1'b1, 8, 1'b1, -1, 1'b0);
        check_outputs("read_at_load");
        pulse_read("read_at_load_clr");

        send_frame(8'h81, 8, 6, 1'b1, 0, 1'b0, -1, 1'b0);
        send_frame(8'h42, 8, 6, 1'b1, 8, 1'b0, -1, 1'b0);
        check_outputs("back_to_back");
        pulse_read("b2b_read");

        send_frame(8'hC3, 3, 2, 1'b1, 8, 1'b0, -1, 1'b1);
        check_outputs("clamped_cfg");

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 2) == 0) pulse_read("rnd_read");
            d  = 8'($urandom);
            ds = $urandom_range(0, 15);
            bp = $urandom_range(0, 24);
            st = ($urandom_range(0, 3) != 0);
            rl = st && ($urandom_range(0, 3) == 0);
            send_frame(d, ds, bp, st, 8, rl, -1, 1'b1);
            check_outputs("rnd_frame");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
